// File: rtl/ahb_master_arbiter.sv
// ----------------------------------------------------------------------------
// ahb_master_arbiter
//
// Round-robin arbiter for a multi-master AHB fabric. Exactly one master holds
// the grant at a time. Ownership can change only at an arbitration point
// (AP). An AP is an accepted IDLE cycle, or the accepted final beat of a
// SINGLE or fixed-length burst. An INCR burst can be handed over only on an
// accepted IDLE cycle.
//
// Ports
//   clk          bus clock, rising edge
//   rst          synchronous, active-high reset
//   req          per-master bus request
//   lock         per-master locked-sequence request
//   trans        shared-bus HTRANS (IDLE, BUSY, NONSEQ, SEQ)
//   burst        shared-bus HBURST
//   ready        shared-bus transfer done
//   grant        one-hot registered grant (master 0 parked after reset)
//   addr_sel     index of the granted master (address-phase mux select)
//   data_sel     index of the master owning the current data phase
//   master_lock  the granted master holds a locked sequence
// ----------------------------------------------------------------------------
module ahb_master_arbiter #(
    parameter int MASTERS = 4,
    parameter int SEL_W   = $clog2(MASTERS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [MASTERS-1:0] req,
    input  logic [MASTERS-1:0] lock,
    input  logic [1:0]         trans,
    input  logic [2:0]         burst,
    input  logic               ready,
    output logic [MASTERS-1:0] grant,
    output logic [SEL_W-1:0]   addr_sel,
    output logic [SEL_W-1:0]   data_sel,
    output logic               master_lock
);

    typedef enum logic [1:0] {
        TR_IDLE   = 2'd0,
        TR_BUSY   = 2'd1,
        TR_NONSEQ = 2'd2,
        TR_SEQ    = 2'd3
    } trans_e;

    // The longest fixed burst is 16 beats, so 5 bits hold any beat index.
    localparam int CNT_W = 5;

    trans_e             trans_t;
    logic [MASTERS-1:0] grant_q,       grant_d;
    logic [SEL_W-1:0]   addr_sel_q,    addr_sel_d;
    logic [SEL_W-1:0]   data_sel_q,    data_sel_d;
    logic [SEL_W-1:0]   rr_ptr_q,      rr_ptr_d;
    logic               master_lock_q, master_lock_d;
    logic [CNT_W-1:0]   beat_cnt_q,    beat_cnt_d;

    logic [CNT_W-1:0]   burst_len;
    logic               len_valid;
    logic [CNT_W-1:0]   beat_idx;
    logic               last_beat;
    logic               arb_point;
    logic [SEL_W-1:0]   next_owner;
    logic               found;
    int                 cand;

    assign trans_t = trans_e'(trans);

    // Burst length decode. INCR has no defined length, so it never produces
    // last_beat and can only be handed over on IDLE.
    always_comb begin
        // NOTE: every signal driven in a combinational block gets a default
        // first, so no path leaves it unassigned and a latch is never inferred.
        burst_len = CNT_W'(1);
        len_valid = 1'b1;
        case (burst)
            3'd0:       burst_len = CNT_W'(1);
            3'd1:       len_valid = 1'b0;
            3'd2, 3'd3: burst_len = CNT_W'(4);
            3'd4, 3'd5: burst_len = CNT_W'(8);
            default:    burst_len = CNT_W'(16);
        endcase
    end

    // Beat index including the beat currently on the bus.
    always_comb begin
        beat_idx = beat_cnt_q;
        case (trans_t)
            TR_NONSEQ: beat_idx = CNT_W'(1);
            TR_SEQ:    beat_idx = beat_cnt_q + CNT_W'(1);
            default:   beat_idx = beat_cnt_q;
        endcase
    end

    assign last_beat = ((trans_t == TR_NONSEQ) || (trans_t == TR_SEQ)) &&
                       len_valid && (beat_idx == burst_len);
    assign arb_point = ready && ((trans_t == TR_IDLE) || last_beat);

    // Next-owner selection. A locked owner that is still requesting keeps the
    // bus. Otherwise the search starts at owner+1 and wraps, which places the
    // current owner last. With no requests at all, the bus parks on master 0.
    always_comb begin
        next_owner = '0;
        found      = 1'b0;
        cand       = 0;
        if (lock[rr_ptr_q] && req[rr_ptr_q]) begin
            next_owner = rr_ptr_q;
            found      = 1'b1;
        end else begin
            for (int i = 1; i <= MASTERS; i++) begin
                cand = int'(rr_ptr_q) + i;
                if (cand >= MASTERS) begin
                    cand = cand - MASTERS;
                end
                if (!found && req[cand]) begin
                    next_owner = SEL_W'(cand);
                    found      = 1'b1;
                end
            end
        end
    end

    // Next-state logic. Nothing moves while ready is low. data_sel takes the
    // previous addr_sel on every accepted transfer, so after a handover the
    // old master's final data phase is still muxed correctly.
    always_comb begin
        grant_d       = grant_q;
        addr_sel_d    = addr_sel_q;
        data_sel_d    = data_sel_q;
        rr_ptr_d      = rr_ptr_q;
        master_lock_d = master_lock_q;
        beat_cnt_d    = beat_cnt_q;
        if (ready) begin
            data_sel_d = addr_sel_q;
            case (trans_t)
                TR_NONSEQ: beat_cnt_d = CNT_W'(1);
                TR_SEQ:    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                TR_IDLE:   beat_cnt_d = '0;
                default:   beat_cnt_d = beat_cnt_q;
            endcase
            if (arb_point) begin
                grant_d             = '0;
                grant_d[next_owner] = 1'b1;
                addr_sel_d          = next_owner;
                rr_ptr_d            = next_owner;
                master_lock_d       = lock[next_owner] && req[next_owner];
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers take non-blocking assignments, so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            grant_q       <= MASTERS'(1);
            addr_sel_q    <= '0;
            data_sel_q    <= '0;
            rr_ptr_q      <= '0;
            master_lock_q <= 1'b0;
            beat_cnt_q    <= '0;
        end else begin
            grant_q       <= grant_d;
            addr_sel_q    <= addr_sel_d;
            data_sel_q    <= data_sel_d;
            rr_ptr_q      <= rr_ptr_d;
            master_lock_q <= master_lock_d;
            beat_cnt_q    <= beat_cnt_d;
        end
    end

    assign grant       = grant_q;
    assign addr_sel    = addr_sel_q;
    assign data_sel    = data_sel_q;
    assign master_lock = master_lock_q;

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ahb_master_arbiter
//
// Bench for ahb_master_arbiter with MASTERS = 4. It runs a hand-written
// vector table covering reset, round robin, a fixed burst, wait states, lock,
// INCR, parking and a mid-burst reset. It then runs randomized traffic
// against a behavioural model built from the arbitration rules.
// ----------------------------------------------------------------------------
module tb_ahb_master_arbiter;

    localparam int M = 4;
    localparam int S = 2;

    localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, NS = 2'd2, SQ = 2'd3;

    logic         clk = 1'b0;
    logic         rst;
    logic [M-1:0] req, lock;
    logic [1:0]   trans;
    logic [2:0]   burst;
    logic         ready;
    logic [M-1:0] grant;
    logic [S-1:0] addr_sel, data_sel;
    logic         master_lock;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ahb_master_arbiter #(.MASTERS(M)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .lock        (lock),
        .trans       (trans),
        .burst       (burst),
        .ready       (ready),
        .grant       (grant),
        .addr_sel    (addr_sel),
        .data_sel    (data_sel),
        .master_lock (master_lock)
    );

    typedef struct {
        logic         rst;
        logic [M-1:0] req;
        logic [M-1:0] lock;
        logic [1:0]   trans;
        logic [2:0]   burst;
        logic         ready;
        logic [M-1:0] exp_grant;
        logic [S-1:0] exp_addr;
        logic [S-1:0] exp_data;
        logic         exp_ml;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic [M-1:0] rq, input logic [M-1:0] lk,
                       input logic [1:0] tr, input logic [2:0] bu, input logic rd,
                       input logic [M-1:0] g, input logic [S-1:0] a, input logic [S-1:0] d,
                       input logic ml);
        vec_t v;
        v.rst = r;        v.req = rq;      v.lock = lk;     v.trans = tr;
        v.burst = bu;     v.ready = rd;    v.exp_grant = g; v.exp_addr = a;
        v.exp_data = d;   v.exp_ml = ml;
        vq.push_back(v);
    endtask

    task automatic check_outs(input string tag, input logic [M-1:0] g, input logic [S-1:0] a,
                              input logic [S-1:0] d, input logic ml);
        check({tag, " grant"},       32'(grant),       32'(g));
        check({tag, " addr_sel"},    32'(addr_sel),    32'(a));
        check({tag, " data_sel"},    32'(data_sel),    32'(d));
        check({tag, " master_lock"}, 32'(master_lock), 32'(ml));
    endtask

    // ---------------- behavioural reference model ----------------
    int m_owner, m_cnt, m_dsel;
    bit m_ml;

    function automatic int blen(input logic [2:0] b);
        case (b)
            3'd0:       return 1;
            3'd1:       return 0;  // INCR: length undefined
            3'd2, 3'd3: return 4;
            3'd4, 3'd5: return 8;
            default:    return 16;
        endcase
    endfunction

    task automatic model_reset();
        m_owner = 0; m_cnt = 0; m_dsel = 0; m_ml = 0;
    endtask

    task automatic model_step();
        int  beat, len, nxt;
        bit  ap;
        if (rst) begin
            model_reset();
            return;
        end
        if (!ready) return;
        len  = blen(burst);
        beat = (trans == NS) ? 1 : (trans == SQ) ? m_cnt + 1 : m_cnt;
        ap   = (trans == IDLE) ||
               ((trans == NS || trans == SQ) && len != 0 && beat == len);
        m_dsel = m_owner;
        if (trans == NS) m_cnt = 1;
        else if (trans == SQ) m_cnt = m_cnt + 1;
        else if (trans == IDLE) m_cnt = 0;
        if (ap) begin
            if (lock[m_owner] && req[m_owner]) begin
                nxt = m_owner;
            end else begin
                nxt = 0;  // park when nobody asks
                for (int k = 1; k <= M; k++) begin
                    if (req[(m_owner + k) % M]) begin
                        nxt = (m_owner + k) % M;
                        break;
                    end
                end
            end
            m_owner = nxt;
            m_ml    = lock[nxt] && req[nxt];
        end
    endtask

    initial begin
        rst = 1'b1; req = '0; lock = '0; trans = IDLE; burst = 3'd0; ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 4'b0001, 2'd0, 2'd0, 1'b0);
        rst = 1'b0;

        // rst  req      lock     trans burst rdy  grant    addr  data  ml
        add(0, 4'b0000, 4'b0000, IDLE, 3'd0, 1, 4'b0001, 2'd0, 2'd0, 0);  // park
        add(0, 4'b1111, 4'b0000, NS,   3'd0, 1, 4'b0010, 2'd1, 2'd0, 0);  // round robin
        add(0, 4'b1111, 4'b0000, NS,   3'd0, 1, 4'b0100, 2'd2, 2'd1, 0);
        add(0, 4'b1111, 4'b0000, NS,   3'd0, 1, 4'b1000, 2'd3, 2'd2, 0);
        add(0, 4'b1111, 4'b0000, NS,   3'd0, 1, 4'b0001, 2'd0, 2'd3, 0);
        add(0, 4'b1111, 4'b0000, NS,   3'd0, 1, 4'b0010, 2'd1, 2'd0, 0);
        add(0, 4'b1111, 4'b0000, NS,   3'd0, 1, 4'b0100, 2'd2, 2'd1, 0);
        add(0, 4'b1111, 4'b0000, NS,   3'd3, 1, 4'b0100, 2'd2, 2'd2, 0);  // INCR4 by master 2
        add(0, 4'b1111, 4'b0000, SQ,   3'd3, 1, 4'b0100, 2'd2, 2'd2, 0);
        add(0, 4'b1111, 4'b0000, SQ,   3'd3, 1, 4'b0100, 2'd2, 2'd2, 0);
        add(0, 4'b1111, 4'b0000, SQ,   3'd3, 1, 4'b1000, 2'd3, 2'd2, 0);  // beat 4 -> handover
        add(0, 4'b1111, 4'b0000, NS,   3'd4, 1, 4'b1000, 2'd3, 2'd3, 0);  // WRAP8 beat 1
        for (int w = 0; w < 3; w++)
            add(0, 4'b1111, 4'b0000, SQ, 3'd4, 0, 4'b1000, 2'd3, 2'd3, 0); // wait states
        for (int b = 2; b <= 7; b++)
            add(0, 4'b1111, 4'b0000, SQ, 3'd4, 1, 4'b1000, 2'd3, 2'd3, 0);
        add(0, 4'b1111, 4'b0000, SQ,   3'd4, 1, 4'b0001, 2'd0, 2'd3, 0);  // beat 8 -> handover
        add(0, 4'b1111, 4'b0000, IDLE, 3'd0, 0, 4'b0001, 2'd0, 2'd3, 0);  // data_sel frozen
        add(0, 4'b1111, 4'b0000, IDLE, 3'd0, 1, 4'b0010, 2'd1, 2'd0, 0);
        add(0, 4'b1111, 4'b0010, NS,   3'd0, 1, 4'b0010, 2'd1, 2'd1, 1);  // lock by master 1
        add(0, 4'b1111, 4'b0010, NS,   3'd0, 1, 4'b0010, 2'd1, 2'd1, 1);
        add(0, 4'b1111, 4'b0000, NS,   3'd0, 1, 4'b0100, 2'd2, 2'd1, 0);  // lock dropped
        add(0, 4'b1111, 4'b1000, NS,   3'd0, 1, 4'b1000, 2'd3, 2'd2, 1);  // non-owner lock
        add(0, 4'b1111, 4'b0000, NS,   3'd0, 1, 4'b0001, 2'd0, 2'd3, 0);
        add(0, 4'b1000, 4'b0000, NS,   3'd0, 1, 4'b1000, 2'd3, 2'd0, 0);
        add(0, 4'b1111, 4'b0000, NS,   3'd1, 1, 4'b1000, 2'd3, 2'd3, 0);  // INCR by master 3
        add(0, 4'b1111, 4'b0000, SQ,   3'd1, 1, 4'b1000, 2'd3, 2'd3, 0);
        add(0, 4'b1111, 4'b0000, BUSY, 3'd1, 1, 4'b1000, 2'd3, 2'd3, 0);
        add(0, 4'b1111, 4'b0000, SQ,   3'd1, 1, 4'b1000, 2'd3, 2'd3, 0);
        add(0, 4'b1111, 4'b0000, IDLE, 3'd1, 0, 4'b1000, 2'd3, 2'd3, 0);  // IDLE not accepted
        add(0, 4'b1111, 4'b0000, IDLE, 3'd1, 1, 4'b0001, 2'd0, 2'd3, 0);  // accepted IDLE
        add(0, 4'b0000, 4'b0000, IDLE, 3'd0, 1, 4'b0001, 2'd0, 2'd0, 0);
        add(0, 4'b0100, 4'b0000, IDLE, 3'd0, 1, 4'b0100, 2'd2, 2'd0, 0);
        add(0, 4'b0000, 4'b0000, IDLE, 3'd0, 1, 4'b0001, 2'd0, 2'd2, 0);  // park from 2
        add(0, 4'b0010, 4'b0000, NS,   3'd0, 1, 4'b0010, 2'd1, 2'd0, 0);
        add(0, 4'b1111, 4'b0000, NS,   3'd3, 1, 4'b0010, 2'd1, 2'd1, 0);  // INCR4 beat 1
        add(1, 4'b1111, 4'b0000, SQ,   3'd3, 1, 4'b0001, 2'd0, 2'd0, 0);  // reset mid-burst
        add(0, 4'b1111, 4'b0000, SQ,   3'd3, 1, 4'b0001, 2'd0, 2'd0, 0);  // counter restarted
        add(0, 4'b1111, 4'b0000, SQ,   3'd3, 1, 4'b0001, 2'd0, 2'd0, 0);
        add(0, 4'b1111, 4'b0000, SQ,   3'd3, 1, 4'b0001, 2'd0, 2'd0, 0);
        add(0, 4'b1111, 4'b0000, SQ,   3'd3, 1, 4'b0010, 2'd1, 2'd0, 0);

        foreach (vq[i]) begin
            rst = vq[i].rst; req = vq[i].req; lock = vq[i].lock;
            trans = vq[i].trans; burst = vq[i].burst; ready = vq[i].ready;
            @(posedge clk);
            #1;
            check_outs($sformatf("vec%0d", i), vq[i].exp_grant, vq[i].exp_addr,
                       vq[i].exp_data, vq[i].exp_ml);
        end

        // Randomized traffic against the model, starting from a clean reset.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        burst = 3'd0;
        for (int n = 0; n < 3000; n++) begin
            int r;
            rst  = ($urandom_range(0, 199) == 0);
            req  = M'($urandom);
            lock = ($urandom_range(0, 3) == 0) ? M'($urandom) : '0;
            if ($urandom_range(0, 15) == 0) burst = 3'($urandom);
            r = $urandom_range(0, 99);
            trans = (r < 30) ? NS : (r < 75) ? SQ : (r < 90) ? IDLE : BUSY;
            ready = ($urandom_range(0, 3) != 0);
            model_step();
            @(posedge clk);
            #1;
            check_outs($sformatf("rand%0d", n), M'(1 << m_owner), S'(m_owner),
                       S'(m_dsel), m_ml);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
